// File: rtl/bp_window_reg_pkg.sv
// bp_pkg: shared base-pair types, encodings and operation decode for the Q/R alignment datapath
package bp_pkg;
  localparam int BP_W_DFLT = 3;
  typedef logic [BP_W_DFLT-1:0] bp_t;
  localparam bp_t BP_A = 3'd0;
  localparam bp_t BP_C = 3'd1;
  localparam bp_t BP_G = 3'd2;
  localparam bp_t BP_T = 3'd3;
  localparam bp_t BP_N = 3'd4;
  typedef enum logic [1:0] {OP_IDLE, OP_SHIFT, OP_LOAD, OP_CLR} op_e;
endpackage

// File: rtl/bp_window_reg_if.sv
// bp_window_reg_if: serial input handshake, control and window outputs of the base-pair window
interface bp_window_reg_if #(
  parameter int BP_W  = 3,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic [BP_W-1:0]       in_bp;
  logic                  in_valid;
  logic                  in_ready;
  logic                  dir;
  logic                  hold;
  logic                  load;
  logic [DEPTH*BP_W-1:0] load_data;
  logic                  clr;
  logic [DEPTH*BP_W-1:0] out;
  logic [CNT_W-1:0]      fill;
  logic                  full;
  logic [BP_W-1:0]       out_bp;
  logic                  out_bp_valid;
  modport master (
    output in_bp, in_valid, dir, hold, load, load_data, clr,
    input  in_ready, out, fill, full, out_bp, out_bp_valid
  );
  modport slave (
    input  in_bp, in_valid, dir, hold, load, load_data, clr,
    output in_ready, out, fill, full, out_bp, out_bp_valid
  );
endinterface

// File: rtl/bp_window_reg_fill_ctr.sv
// bp_fill_ctr: saturating 0..MAX occupancy counter with clear, load-to-max and full flag
module bp_fill_ctr #(
  parameter int MAX = 4,
  localparam int W  = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         set_max,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         full
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb begin
    full  = cnt_q == W'(MAX);
    cnt_d = clr ? '0 : set_max ? W'(MAX) : (inc && !full) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/bp_window_reg.sv
// bp_window_reg: DEPTH-base shift window with handshake, parallel load, clear, occupancy and eviction output
module bp_window_reg
  import bp_pkg::*;
#(
  parameter int BP_W  = BP_W_DFLT,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst,
  bp_window_reg_if.slave   bus
);
  logic [DEPTH*BP_W-1:0] win_d, win_q;
  logic [BP_W-1:0]       out_bp_d, out_bp_q, evict;
  logic                  out_bp_valid_d, out_bp_valid_q;
  logic                  in_ready, full;
  logic [CNT_W-1:0]      fill;
  op_e                   op;
  always_comb begin
    in_ready = !bus.hold && !bus.load && !bus.clr && !rst;
    op       = bus.clr ? OP_CLR : bus.load ? OP_LOAD : (bus.in_valid && in_ready) ? OP_SHIFT : OP_IDLE;
    evict    = bus.dir ? win_q[(DEPTH-1)*BP_W +: BP_W] : win_q[BP_W-1:0];
    win_d    = op == OP_CLR   ? '0 :
               op == OP_LOAD  ? bus.load_data :
               op == OP_SHIFT ? (bus.dir ? {win_q[(DEPTH-1)*BP_W-1:0], bus.in_bp}
                                         : {bus.in_bp, win_q[DEPTH*BP_W-1:BP_W]}) :
               win_q;
    out_bp_d       = op == OP_SHIFT ? evict : out_bp_q;
    // An evicted base is only genuine once the window was completely filled
    out_bp_valid_d = op == OP_SHIFT && full;
  end
  always_ff @(posedge clk)
    if (rst) begin
      win_q          <= '0;
      out_bp_q       <= '0;
      out_bp_valid_q <= 1'b0;
    end else begin
      win_q          <= win_d;
      out_bp_q       <= out_bp_d;
      out_bp_valid_q <= out_bp_valid_d;
    end
  bp_fill_ctr #(.MAX(DEPTH)) u_fill (
    .clk     (clk),
    .rst     (rst),
    .clr     (op == OP_CLR),
    .set_max (op == OP_LOAD),
    .inc     (op == OP_SHIFT),
    .cnt     (fill),
    .full    (full)
  );
  assign bus.in_ready     = in_ready;
  assign bus.out          = win_q;
  assign bus.fill         = fill;
  assign bus.full         = full;
  assign bus.out_bp       = out_bp_q;
  assign bus.out_bp_valid = out_bp_valid_q;
endmodule

// File: doc/bp_window_reg.md
Name: bp_window_reg

Overview:
- Parametrised base-pair window register for the Q/R alignment datapath. It is the next-generation replacement for the fixed 4-base, 3-bit shift register.
- Holds DEPTH bases of BP_W bits each and shifts one base per accepted serial input, left (R) or right (Q).
- Adds a valid/ready input handshake, parallel load, synchronous clear, occupancy tracking and an evicted-base output, so upstream sequence readers and downstream comparators can stall cleanly.

Parameters:
- BP_W, 3, bits per base pair
- DEPTH, 4, number of base-pair slots, must be >= 2
- CNT_W, $clog2(DEPTH+1), width of the fill counter (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- in_bp  in  BP_W  serial base input
- in_valid  in  1  in_bp is valid this cycle
- in_ready  out  1  block accepts in_bp this cycle (combinational)
- dir  in  1  1 = left shift (R): new base enters slot 0 (LSBs). 0 = right shift (Q): new base enters slot DEPTH-1 (MSBs)
- hold  in  1  downstream stall; blocks shifting
- load  in  1  parallel-load request
- load_data  in  DEPTH*BP_W  parallel-load value
- clr  in  1  synchronous clear of contents and occupancy
- out  out  DEPTH*BP_W  window contents; slot i = out[i*BP_W +: BP_W]
- fill  out  CNT_W  number of bases shifted or loaded since the last clear, saturating at DEPTH
- full  out  1  fill == DEPTH
- out_bp  out  BP_W  base evicted by the last shift
- out_bp_valid  out  1  one-cycle pulse: out_bp holds a genuine evicted base

Behaviour:
- Reset (rst=1 at posedge): out=0, fill=0, out_bp=0, out_bp_valid=0. Reset takes priority over every other input.
- in_ready = !hold && !load && !clr && !rst.
- Shift event: in_valid && in_ready. All registered outputs update at the same posedge, so latency is 1 cycle.
- Priority per cycle is rst > clr > load > shift > idle.
- clr: out=0, fill=0, out_bp_valid=0. out_bp is held.
- load: out=load_data, fill=DEPTH, out_bp_valid=0. The in_bp presented that cycle is not consumed, because in_ready=0.
- Shift with dir=1: out <= {out[(DEPTH-1)*BP_W-1:0], in_bp}. The evicted base is the old slot DEPTH-1.
- Shift with dir=0: out <= {in_bp, out[DEPTH*BP_W-1:BP_W]}. The evicted base is the old slot 0.
- On every shift, out_bp <= evicted base.
- On a shift, out_bp_valid <= 1 only if full was 1 before that shift; otherwise 0.
- fill increments on each shift and saturates at DEPTH, with no wrap.
- Idle cycles: out, fill and out_bp hold; out_bp_valid <= 0.
- dir may change on any cycle, including while not full. fill still counts shifts, and out follows the shift equations exactly. Validity of evicted bases is defined only through full.
- in_valid while in_ready=0: no state change. The producer must hold in_bp until accepted.
- rst or clr mid-fill discards partial contents. There is no residual out_bp_valid pulse.

Decomposition:
- Shared package bp_pkg:
  - BP_W default
  - base encoding constants (A, C, G, T, N/gap)
  - a bp_t typedef of BP_W bits
  - an op enum {OP_IDLE, OP_SHIFT, OP_LOAD, OP_CLR} for the priority decode
- One sub-module is natural: bp_fill_ctr, the saturating 0..DEPTH counter with clear/load-to-max and a full flag. It is reused by the comparator scoreboard.
- The shift datapath stays inline.

Test Plan (DEPTH=4, BP_W=3):
- Reset, then shift 1,2,3,4 with dir=1 and in_valid=1 -> out=0x29C, fill=4, full=1 after the 4th edge; out_bp_valid stays 0 throughout.
- From 0x29C, shift in_bp=5 with dir=1 -> out=0x4E5, out_bp=1, out_bp_valid=1 for exactly one cycle; fill stays 4.
- From 0x29C, shift in_bp=7 with dir=0 -> out=0xE53, out_bp=4, out_bp_valid=1.
- load=1, load_data=0xFFF, in_valid=1, in_bp=2 in the same cycle -> in_ready=0, out=0xFFF, fill=4, in_bp not consumed.
- Hold and clear: hold=1 for 3 cycles with in_valid=1 -> out and fill unchanged. Then clr=1 -> out=0, fill=0, full=0, out_bp_valid=0.
- Assert rst after 2 of 4 shifts -> out=0 and fill=0 on the next edge. Fill then restarts from 0 with no spurious out_bp_valid.
